// File: rtl/dcu_biu_arb.sv
// Data-cache-unit to bus-interface arbiter: picks one of writeback, miss read
// or non-allocating store, then sequences its 1- or 4-beat memory transaction.
module dcu_biu_arb #(
    parameter int unsigned ST_STARVE_LIM = 3
) (
    input  logic       clk,
    input  logic       reset_l,
    input  logic       wb_req,
    input  logic       rd_req,
    input  logic       rd_nc,
    input  logic       st_req,
    input  logic       normal_ack,
    input  logic       error_ack,
    output logic       biu_req,
    output logic [1:0] biu_type,
    output logic       wb_gnt,
    output logic       rd_gnt,
    output logic       st_gnt,
    output logic       xfer_cyc,
    output logic       last_xfer,
    output logic       req_outstanding,
    output logic       arb_idle,
    output logic       arb_error
);

    localparam int unsigned STARVE_W = (ST_STARVE_LIM < 1) ? 1 : $clog2(ST_STARVE_LIM + 1);

    typedef enum logic [3:0] {
        ST_IDLE = 4'b0001,
        ST_REQ  = 4'b0010,
        ST_XFER = 4'b0100,
        ST_ERR  = 4'b1000
    } state_t;

    typedef enum logic [1:0] {
        BT_LINE_RD = 2'b00,
        BT_WORD_RD = 2'b01,
        BT_LINE_WB = 2'b10,
        BT_WORD_ST = 2'b11
    } btype_t;

    // Grant vector layout is {wb, rd, st}.
    function automatic logic [1:0] type_for_grant(input logic [2:0] gnt, input logic nc);
        logic [1:0] t;
        case (gnt)
            3'b100:  t = BT_LINE_WB;
            3'b010:  t = nc ? BT_WORD_RD : BT_LINE_RD;
            3'b001:  t = BT_WORD_ST;
            default: t = BT_LINE_RD;
        endcase
        return t;
    endfunction

    state_t              state_r;
    state_t              state_next_s;
    logic [1:0]          cnt_r;
    logic [1:0]          cnt_next_s;
    logic [STARVE_W-1:0] starve_r;
    logic [STARVE_W-1:0] starve_next_s;
    logic [2:0]          gnt_r;
    logic [1:0]          type_r;
    logic [2:0]          win_s;
    logic                any_req_s;
    logic                st_force_s;
    logic                word_type_s;
    logic                busy_s;

    assign any_req_s   = wb_req | rd_req | st_req;
    assign st_force_s  = st_req & (starve_r == STARVE_W'(ST_STARVE_LIM));
    // Both word types (01, 11) have bit 0 set.
    assign word_type_s = type_r[0];

    // Fixed priority wb > rd > st, overridden by a starved store.
    always_comb begin
        win_s = 3'b000;
        if (st_force_s) begin
            win_s = 3'b001;
        end else if (wb_req) begin
            win_s = 3'b100;
        end else if (rd_req) begin
            win_s = 3'b010;
        end else if (st_req) begin
            win_s = 3'b001;
        end else begin
            win_s = 3'b000;
        end
    end

    // Store starvation counter, only advanced by an IDLE arbitration.
    always_comb begin
        starve_next_s = starve_r;
        if (state_r == ST_IDLE) begin
            if (!st_req || win_s[0]) begin
                starve_next_s = '0;
            end else if (starve_r != STARVE_W'(ST_STARVE_LIM)) begin
                starve_next_s = starve_r + STARVE_W'(1);
            end else begin
                starve_next_s = starve_r;
            end
        end else begin
            starve_next_s = starve_r;
        end
    end

    // Next-state and beat-count logic; error_ack takes precedence over normal_ack.
    always_comb begin
        state_next_s = state_r;
        cnt_next_s   = cnt_r;
        case (state_r)
            ST_IDLE: begin
                cnt_next_s = 2'd0;
                if (any_req_s) begin
                    state_next_s = ST_REQ;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (error_ack) begin
                    state_next_s = ST_ERR;
                end else if (normal_ack) begin
                    if (word_type_s) begin
                        state_next_s = ST_IDLE;
                        cnt_next_s   = 2'd0;
                    end else begin
                        state_next_s = ST_XFER;
                        cnt_next_s   = 2'd1;
                    end
                end else begin
                    state_next_s = ST_REQ;
                end
            end
            ST_XFER: begin
                if (error_ack) begin
                    state_next_s = ST_ERR;
                end else if (normal_ack) begin
                    if (cnt_r == 2'd3) begin
                        state_next_s = ST_IDLE;
                        cnt_next_s   = 2'd0;
                    end else begin
                        state_next_s = ST_XFER;
                        cnt_next_s   = cnt_r + 2'd1;
                    end
                end else begin
                    state_next_s = ST_XFER;
                end
            end
            ST_ERR: begin
                state_next_s = ST_IDLE;
                cnt_next_s   = 2'd0;
            end
            default: begin
                state_next_s = ST_IDLE;
                cnt_next_s   = 2'd0;
            end
        endcase
    end

    // State, beat count and starvation registers.
    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            state_r  <= ST_IDLE;
            cnt_r    <= 2'd0;
            starve_r <= '0;
        end else begin
            state_r  <= state_next_s;
            cnt_r    <= cnt_next_s;
            starve_r <= starve_next_s;
        end
    end

    // Grant and type are captured at arbitration and held until IDLE is re-entered.
    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            gnt_r  <= 3'b000;
            type_r <= BT_LINE_RD;
        end else if (state_next_s == ST_IDLE) begin
            gnt_r  <= 3'b000;
            type_r <= BT_LINE_RD;
        end else if (state_r == ST_IDLE) begin
            gnt_r  <= win_s;
            type_r <= type_for_grant(win_s, rd_nc);
        end else begin
            gnt_r  <= gnt_r;
            type_r <= type_r;
        end
    end

    assign busy_s          = (state_r == ST_REQ) | (state_r == ST_XFER);
    assign biu_req         = (state_r == ST_REQ);
    assign biu_type        = type_r;
    assign wb_gnt          = gnt_r[2];
    assign rd_gnt          = gnt_r[1];
    assign st_gnt          = gnt_r[0];
    assign xfer_cyc        = normal_ack & ~error_ack & busy_s;
    assign last_xfer       = xfer_cyc & (((state_r == ST_REQ) & word_type_s) |
                                         ((state_r == ST_XFER) & (cnt_r == 2'd3)));
    assign req_outstanding = (state_r != ST_IDLE);
    assign arb_idle        = (state_r == ST_IDLE);
    assign arb_error       = (state_r == ST_ERR);

endmodule

// File: tb/tb_dcu_biu_arb.sv
// Directed bench for dcu_biu_arb: a transaction-level model checked every cycle,
// plus literal expectations for the headline scenarios.
module tb_dcu_biu_arb;
    localparam int LIM = 3;

    logic clk = 1'b0;
    logic reset_l = 1'b0;
    logic wb_req = 1'b0, rd_req = 1'b0, rd_nc = 1'b0, st_req = 1'b0;
    logic normal_ack = 1'b0, error_ack = 1'b0;
    logic biu_req, wb_gnt, rd_gnt, st_gnt, xfer_cyc, last_xfer;
    logic req_outstanding, arb_idle, arb_error;
    logic [1:0] biu_type;

    dcu_biu_arb #(.ST_STARVE_LIM(LIM)) dut (
        .clk(clk), .reset_l(reset_l), .wb_req(wb_req), .rd_req(rd_req), .rd_nc(rd_nc),
        .st_req(st_req), .normal_ack(normal_ack), .error_ack(error_ack),
        .biu_req(biu_req), .biu_type(biu_type), .wb_gnt(wb_gnt), .rd_gnt(rd_gnt),
        .st_gnt(st_gnt), .xfer_cyc(xfer_cyc), .last_xfer(last_xfer),
        .req_outstanding(req_outstanding), .arb_idle(arb_idle), .arb_error(arb_error));

    always #5 clk = ~clk;

    // Transaction model: owner 0=wb 1=rd 2=st, beats taken out of a 1- or 4-beat length.
    logic       m_active, m_err;
    int         m_beats, m_len, m_owner, m_starve;
    logic [1:0] m_type;

    function automatic int pick(input logic wb, input logic rd, input logic st, input int s);
        if (st && s == LIM) return 2;
        if (wb) return 0;
        if (rd) return 1;
        return 2;
    endfunction
    function automatic int wlen(input int w, input logic nc);
        return (w == 2 || (w == 1 && nc)) ? 1 : 4;
    endfunction
    function automatic logic [1:0] wtype(input int w, input logic nc);
        if (w == 0) return 2'b10;
        if (w == 2) return 2'b11;
        return nc ? 2'b01 : 2'b00;
    endfunction

    always @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            m_active <= 1'b0; m_err <= 1'b0; m_beats <= 0; m_len <= 1;
            m_owner <= 3; m_starve <= 0; m_type <= 2'b00;
        end else if (m_err) begin
            m_err <= 1'b0;
        end else if (m_active) begin
            if (error_ack) begin
                m_active <= 1'b0; m_err <= 1'b1;
            end else if (normal_ack) begin
                if (m_beats + 1 == m_len) m_active <= 1'b0;
                m_beats <= m_beats + 1;
            end
        end else if (wb_req || rd_req || st_req) begin
            m_active <= 1'b1;
            m_beats  <= 0;
            m_owner  <= pick(wb_req, rd_req, st_req, m_starve);
            m_len    <= wlen(pick(wb_req, rd_req, st_req, m_starve), rd_nc);
            m_type   <= wtype(pick(wb_req, rd_req, st_req, m_starve), rd_nc);
            m_starve <= (pick(wb_req, rd_req, st_req, m_starve) == 2 || !st_req) ? 0 :
                        (m_starve < LIM ? m_starve + 1 : m_starve);
        end else begin
            m_starve <= 0;
        end
    end

    function automatic logic [10:0] exp_vec();
        logic busy, x;
        busy = m_active || m_err;
        x    = m_active && normal_ack && !error_ack;
        return {m_active && m_beats == 0, busy ? m_type : 2'b00,
                busy && m_owner == 0, busy && m_owner == 1, busy && m_owner == 2,
                x, x && (m_beats == m_len - 1), busy, !busy, m_err};
    endfunction

    function automatic logic [10:0] act_vec();
        return {biu_req, biu_type, wb_gnt, rd_gnt, st_gnt, xfer_cyc, last_xfer,
                req_outstanding, arb_idle, arb_error};
    endfunction

    function automatic int owner_of(input logic w, input logic r, input logic s);
        return w ? 0 : (r ? 1 : (s ? 2 : 3));
    endfunction

    int    checks = 0, errors = 0;
    int    req_seq = 0, done_seq = 0;
    string pend_name;
    int    pend_got, pend_exp;
    int    gq[$], bq[$], lq[$];
    int    breq_cycles = 0, err_cycles = 0, err_owner = 3;
    logic  prev_breq = 1'b0;
    logic [1:0] last_type = 2'b00;

    // Single compare process: model check every cycle, directed checks on request.
    always @(negedge clk) begin
        checks++;
        if (act_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL outputs t=%0t got=%b exp=%b", $time, act_vec(), exp_vec());
        end
        if (req_seq != done_seq) begin
            checks++;
            if (pend_got != pend_exp) begin
                errors++;
                $display("FAIL %s got=%0d exp=%0d", pend_name, pend_got, pend_exp);
            end
            done_seq = req_seq;
        end
        if (biu_req && !prev_breq) gq.push_back(owner_of(wb_gnt, rd_gnt, st_gnt));
        if (xfer_cyc) bq.push_back(owner_of(wb_gnt, rd_gnt, st_gnt));
        if (last_xfer) lq.push_back(bq.size());
        if (biu_req) begin breq_cycles++; last_type = biu_type; end
        if (arb_error) begin err_cycles++; err_owner = owner_of(wb_gnt, rd_gnt, st_gnt); end
        prev_breq = biu_req;
    end

    task automatic chk(input string name, input int got, input int expv);
        pend_name = name; pend_got = got; pend_exp = expv;
        req_seq++;
        wait (done_seq == req_seq);
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    // Digits (owner+1) of queue entries from base, most significant first.
    function automatic int digits(input int q[$], input int base, input int n);
        int v = 0;
        for (int i = 0; i < n && base + i < q.size(); i++) v = v * 10 + q[base + i] + 1;
        return v;
    endfunction

    int b0, l0, g0, c0, e0, v_idle, v_err, v_gnt, v_x;
    logic [10:0] v;

    initial begin
        // Reset holds everything idle even with requests and acks present.
        wb_req = 1'b1; normal_ack = 1'b1;
        repeat (3) tick();
        v = act_vec();
        chk("reset_outputs", int'(v), 2);
        wb_req = 1'b0; normal_ack = 1'b0;
        tick();
        reset_l = 1'b1;
        tick();

        // Acks while idle are ignored.
        normal_ack = 1'b1; error_ack = 1'b1; tick();
        error_ack = 1'b0; tick();
        normal_ack = 1'b0;
        chk("idle_acks_idle", int'(arb_idle), 1);
        chk("idle_acks_noerr", err_cycles, 0);

        // Three simultaneous requests, ack every cycle: wb x4, rd x4, st x1.
        b0 = bq.size(); l0 = lq.size();
        wb_req = 1'b1; rd_req = 1'b1; st_req = 1'b1; normal_ack = 1'b1;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (wb_gnt) wb_req = 1'b0;
            if (rd_gnt) rd_req = 1'b0;
            if (st_gnt) st_req = 1'b0;
            if (!wb_req && !rd_req && !st_req && arb_idle) break;
        end
        normal_ack = 1'b0;
        chk("t1_done_idle", int'(arb_idle), 1);
        chk("t1_beats", bq.size() - b0, 9);
        chk("t1_owner_seq", digits(bq, b0, 9), 111122223);
        chk("t1_last_count", lq.size() - l0, 3);
        chk("t1_last_pos", (lq.size() - l0 == 3) ?
            (lq[l0] - b0) * 100 + (lq[l0+1] - b0) * 10 + (lq[l0+2] - b0) : -1, 489);

        // Store held against a continually re-requesting writeback wins the 4th arbitration.
        g0 = gq.size();
        wb_req = 1'b1; rd_req = 1'b1; st_req = 1'b1; normal_ack = 1'b1;
        for (int i = 0; i < 60; i++) begin
            tick();
            if (gq.size() - g0 >= 4) break;
        end
        wb_req = 1'b0; rd_req = 1'b0; st_req = 1'b0;
        tick(); tick();
        normal_ack = 1'b0;
        chk("t2_arb_seq", digits(gq, g0, 4), 1113);

        // Noncacheable read, ack on the 3rd cycle of biu_req.
        c0 = breq_cycles; b0 = bq.size(); l0 = lq.size();
        rd_req = 1'b1; rd_nc = 1'b1;
        tick();
        rd_req = 1'b0; rd_nc = 1'b0;
        tick(); tick();
        normal_ack = 1'b1;
        tick();
        normal_ack = 1'b0;
        v_idle = int'(arb_idle);
        chk("t3_breq_cycles", breq_cycles - c0, 3);
        chk("t3_type", int'(last_type), 1);
        chk("t3_beats", bq.size() - b0, 1);
        chk("t3_last", lq.size() - l0, 1);
        chk("t3_idle", v_idle, 1);

        // Line read with error on the 2nd beat.
        e0 = err_cycles;
        rd_req = 1'b1;
        tick();
        rd_req = 1'b0; normal_ack = 1'b1;
        tick();
        normal_ack = 1'b0; error_ack = 1'b1;
        tick();
        error_ack = 1'b0;
        v_err = int'(arb_error); v_gnt = int'({wb_gnt, rd_gnt, st_gnt});
        tick();
        v_idle = int'(arb_idle);
        chk("t4_err_pulse", v_err, 1);
        chk("t4_gnt_in_err", v_gnt, 2);
        chk("t4_idle_after", v_idle, 1);
        chk("t4_err_cycles", err_cycles - e0, 1);
        chk("t4_err_owner", err_owner, 1);

        // Store with normal_ack and error_ack together in REQ.
        st_req = 1'b1;
        tick();
        st_req = 1'b0; normal_ack = 1'b1; error_ack = 1'b1;
        #1 v_x = int'(xfer_cyc);
        tick();
        normal_ack = 1'b0; error_ack = 1'b0;
        v_err = int'(arb_error);
        chk("t5_xfer_zero", v_x, 0);
        chk("t5_err", v_err, 1);
        tick();

        // Reset mid-burst at count 2, then a fresh full burst.
        e0 = err_cycles;
        rd_req = 1'b1;
        tick();
        rd_req = 1'b0; normal_ack = 1'b1;
        tick(); tick();
        normal_ack = 1'b0;
        reset_l = 1'b0;
        #1 v = act_vec();
        tick();
        reset_l = 1'b1;
        chk("t6_reset_vec", int'(v), 2);
        chk("t6_no_err", err_cycles - e0, 0);
        b0 = bq.size(); l0 = lq.size();
        rd_req = 1'b1;
        tick();
        rd_req = 1'b0; normal_ack = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (arb_idle) break;
        end
        normal_ack = 1'b0;
        chk("t6_idle", int'(arb_idle), 1);
        chk("t6_beats", bq.size() - b0, 4);
        chk("t6_last", lq.size() - l0, 1);
        tick(); tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/dcu_biu_arb.md
DCU_BIU_ARB -- requirements
Module: dcu_biu_arb

Interface
REQ-001 Parameter ST_STARVE_LIM, default 3: consecutive lost arbitrations after which a pending store SHALL win.
REQ-002 clk  input  1  single clock; all state SHALL update on rising edge.
REQ-003 reset_l  input  1  reset; asynchronous, active-low.
REQ-004 wb_req  input  1  dirty-line writeback request (4-word burst).
REQ-005 rd_req  input  1  miss read request.
REQ-006 rd_nc  input  1  qualifies rd_req as noncacheable (1 word); sampled with rd_req.
REQ-007 st_req  input  1  non-allocating store request (1 word).
REQ-008 normal_ack  input  1  memory data beat accepted/valid this cycle.
REQ-009 error_ack  input  1  memory transaction error.
REQ-010 biu_req  output  1  request to bus interface, held until first ack.
REQ-011 biu_type  output  2  00 line read, 01 word read, 10 line writeback, 11 word store.
REQ-012 wb_gnt / rd_gnt / st_gnt  output  1 each  one-hot grant to the owning requester.
REQ-013 xfer_cyc  output  1  data beat this cycle.
REQ-014 last_xfer  output  1  final beat of the current transaction.
REQ-015 req_outstanding  output  1  transaction in progress.
REQ-016 arb_idle  output  1  arbiter in IDLE.
REQ-017 arb_error  output  1  one-cycle pulse after error_ack.

Function
REQ-018 FSM SHALL be one-hot: IDLE, REQ, XFER, ERR; beat counter 2 bits.
REQ-019 IDLE: with any request pending, SHALL pick a winner, latch grant and biu_type, and enter REQ next cycle; otherwise stay.
REQ-020 Priority: wb > rd > st, except that st SHALL win when its starve count equals ST_STARVE_LIM.
REQ-021 Starve count: +1 when st_req is pending and loses; cleared when st wins or st_req is low in IDLE; saturates at ST_STARVE_LIM.
REQ-022 biu_req SHALL equal state==REQ.
REQ-023 Grant and biu_type SHALL be held constant from REQ entry until return to IDLE, including through ERR.
REQ-024 REQ with normal_ack: beat 0 is taken. Word type (01/11) goes to IDLE. Line type goes to XFER with count=1.
REQ-025 XFER with normal_ack: count increments; the ack at count==3 goes to IDLE.
REQ-026 REQ/XFER with no ack: state and count SHALL hold, with unbounded wait.
REQ-027 error_ack in REQ or XFER goes to ERR. ERR lasts one cycle (arb_error=1), then IDLE.
REQ-028 normal_ack and error_ack in the same cycle: error SHALL win, and xfer_cyc SHALL be 0.
REQ-029 Acks received in IDLE or ERR SHALL be ignored.
REQ-030 xfer_cyc = normal_ack & !error_ack & (REQ|XFER).
REQ-031 last_xfer = xfer_cyc & (word type in REQ | count==3 in XFER).
REQ-032 req_outstanding = !IDLE; arb_idle = IDLE.
REQ-033 A requester deasserting while granted SHALL NOT abort the transaction; requests are re-sampled only in IDLE.
REQ-034 After each completion, at least one IDLE cycle SHALL occur; there are no back-to-back grants.

Reset
REQ-035 reset_l low SHALL immediately force IDLE, count=0, and starve count=0.
REQ-036 During reset: arb_idle=1; all other outputs 0; biu_type=00.
REQ-037 Reset asserted mid-burst SHALL abandon the transaction without an arb_error pulse.

Verification
REQ-038 wb_req, rd_req and st_req raised together, with an ack each cycle -> wb_gnt first, burst of 4 beats with last_xfer on beat 4; then rd_gnt, 4 beats; then st_gnt, 1 beat.
REQ-039 st_req held while wb/rd continually re-request -> st_gnt on the 4th arbitration (ST_STARVE_LIM=3).
REQ-040 rd_req with rd_nc=1, ack 3 cycles after biu_req -> biu_type=01, biu_req high 3 cycles, single xfer_cyc with last_xfer, then IDLE.
REQ-041 Line read with error_ack on the 2nd beat -> ERR for 1 cycle, arb_error=1, rd_gnt held through ERR, then arb_idle=1.
REQ-042 Simultaneous normal_ack and error_ack in REQ -> xfer_cyc=0, ERR entered.
REQ-043 reset_l pulsed low during XFER count=2 -> immediately arb_idle=1, grants 0, no arb_error; fresh rd_req then completes a full 4-beat burst.
